fetch_pc_sequencer: RTL

//  Fetch-stage next-PC generator, directly upstream of branch_target_buffer.
//  - Drives fetch_pc to the instruction memory and to the BTB current_pc input.
//  - Consumes the registered BTB prediction one cycle later.
//  - Tracks in-flight predictions in an ordered FIFO.
//  - Redirects fetch and flushes the pipeline when a resolved branch/jump disagrees with its prediction.

---
 rtl/fetch_pc_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage next-PC generator: issues sequential PCs, applies late BTB redirects,
// tracks in-flight predictions and redirects on mispredict. Optional counters: FETCH_PERF_CNT_EN.
module fetch_pc_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic             stall,
    input  logic [63:0]      btb_pred_pc,
    input  logic             res_valid,
    input  logic [63:0]      res_pc,
    input  logic             res_taken,
    input  logic [63:0]      res_target,
    output logic [63:0]      fetch_pc,
    output logic             fetch_valid,
    output logic             flush,
    output logic [PTR_W:0]   inflight_cnt
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_late_pred_cnt,
    output logic [31:0]      perf_mispredict_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_REDIRECT
    } state_t;

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

    state_t             state, state_d;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, tail_ptr;
    logic [PTR_W:0]     cnt;
    logic               pred_chk;
    logic [63:0]        q_pc [DEPTH];
    logic [63:0]        q_pn [DEPTH];

    logic               pop, mispredict, late_hit, has_room, issue, late_upd;
    logic [63:0]        actual, pc_plus4, head_pc, head_pn;

    always_comb begin
        pc_plus4   = fetch_pc + 64'd4;
        tail_ptr   = wr_ptr - PTR_W'(1);
        head_pc    = q_pc[rd_ptr];
        head_pn    = q_pn[rd_ptr];
        pop        = res_valid & (cnt != '0);
        actual     = res_taken ? res_target : (res_pc + 64'd4);
        mispredict = pop & ((actual != head_pn) | (res_pc != head_pc));
        late_hit   = pred_chk & (btb_pred_pc != '0) & (btb_pred_pc != q_pn[tail_ptr]);
        // A same-cycle pop frees a slot, so a full FIFO can still accept a push.
        has_room   = (cnt != DEPTH_C) | pop;
        issue      = (state == S_FETCH) & en & ~stall & has_room & ~late_hit & ~mispredict;
        // Drop the late update if its target entry leaves the FIFO this cycle.
        late_upd   = late_hit & ~mispredict & ~(pop & (cnt == ONE_C));
    end

    assign fetch_valid  = issue;
    assign inflight_cnt = cnt;

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:     if (en) state_d = S_FETCH;
            S_FETCH:    if (mispredict) state_d = S_REDIRECT;
            S_REDIRECT: state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= S_IDLE;
        else         state <= state_d;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            fetch_pc <= RESET_PC;
            flush    <= 1'b0;
            pred_chk <= 1'b0;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            flush    <= mispredict;
            pred_chk <= issue;
            if (mispredict) begin
                fetch_pc <= actual;
                cnt      <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (late_hit)   fetch_pc <= btb_pred_pc;
                else if (issue) fetch_pc <= pc_plus4;
                if (issue) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
                if (issue && !pop)      cnt <= cnt + ONE_C;
                else if (!issue && pop) cnt <= cnt - ONE_C;
            end
        end
    end

    // Entry storage needs no reset: occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (issue) begin
            q_pc[wr_ptr] <= fetch_pc;
            q_pn[wr_ptr] <= pc_plus4;
        end
        if (late_upd) q_pn[tail_ptr] <= btb_pred_pc;
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            perf_fetch_cnt      <= '0;
            perf_late_pred_cnt  <= '0;
            perf_mispredict_cnt <= '0;
        end else begin
            if (issue && perf_fetch_cnt != '1)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (late_hit && perf_late_pred_cnt != '1)
                perf_late_pred_cnt <= perf_late_pred_cnt + 32'd1;
            if (mispredict && perf_mispredict_cnt != '1)
                perf_mispredict_cnt <= perf_mispredict_cnt + 32'd1;
        end
    end
`endif

endmodule
